// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a cyc/ack handshake with instruction
// memory and applies branch/exception redirects. Optional macro: FETCH_PERF_EN (adds perf_wait_o).
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        xcpt_i,
  input  logic [31:0] xcpt_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [3:0]  exc_o,
  output logic        valid_o,
  output logic        busy_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_wait_o
`endif
);

  typedef enum logic [2:0] {
    S_REQ     = 3'd0,
    S_HOLD    = 3'd1,
    S_DISCARD = 3'd2,
    S_FAULT   = 3'd3,
    S_WAIT    = 3'd4
  } state_t;

  localparam logic [3:0] EXC_MISALIGN = 4'b0001;
  localparam logic [3:0] EXC_ACCESS   = 4'b0010;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] buf_r, buf_s;
  logic [31:0] addr_r, addr_s;
  logic [3:0]  exc_r, exc_s;

  logic        redir_s;
  logic [31:0] target_s;
  logic [31:0] pc4_s;
  logic        resp_s;

  logic        cyc_s;
  logic [31:0] addr_out_s;
  logic        valid_s;
  logic [31:0] inst_s;
  logic [3:0]  exc_out_s;
  logic        busy_s;

  // Exception redirects outrank branches.
  assign redir_s  = xcpt_i | branch_i;
  assign target_s = xcpt_i ? xcpt_target_i : branch_target_i;
  assign pc4_s    = pc_r + 32'd4;
  assign resp_s   = iport_ack_i | iport_err_i;

  // Next-state, next-PC and raw output decode.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    buf_s      = buf_r;
    addr_s     = addr_r;
    exc_s      = exc_r;
    cyc_s      = 1'b0;
    addr_out_s = addr_r;
    valid_s    = 1'b0;
    inst_s     = NOP_INST;
    exc_out_s  = 4'b0000;
    busy_s     = 1'b0;
    case (state_r)
      S_REQ: begin
        if (pc_r[1:0] != 2'b00) begin
          // Misaligned PC never reaches the bus.
          if (redir_s) begin
            pc_s = target_s;
          end else begin
            state_s = S_FAULT;
            exc_s   = EXC_MISALIGN;
          end
        end else begin
          cyc_s      = 1'b1;
          addr_out_s = pc_r;
          busy_s     = ~resp_s;
          if (redir_s) begin
            pc_s = target_s;
            if (resp_s) begin
              state_s = S_REQ;
            end else begin
              state_s = S_DISCARD;
              addr_s  = pc_r;
            end
          end else if (iport_err_i) begin
            state_s = S_FAULT;
            exc_s   = EXC_ACCESS;
          end else if (iport_ack_i) begin
            if (stall_i) begin
              buf_s   = iport_data_i;
              state_s = S_HOLD;
            end else begin
              valid_s = 1'b1;
              inst_s  = iport_data_i;
              pc_s    = pc4_s;
            end
          end else begin
            state_s = S_REQ;
          end
        end
      end
      S_HOLD: begin
        valid_s = 1'b1;
        inst_s  = buf_r;
        if (redir_s) begin
          pc_s    = target_s;
          state_s = S_REQ;
        end else if (!stall_i) begin
          pc_s    = pc4_s;
          state_s = S_REQ;
        end else begin
          state_s = S_HOLD;
        end
      end
      S_DISCARD: begin
        // Finish the abandoned bus cycle at its original address; drop the response.
        cyc_s  = 1'b1;
        busy_s = 1'b1;
        if (redir_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
        if (resp_s) begin
          state_s = S_REQ;
        end else begin
          state_s = S_DISCARD;
        end
      end
      S_FAULT: begin
        valid_s   = 1'b1;
        exc_out_s = exc_r;
        if (redir_s) begin
          pc_s    = target_s;
          state_s = S_REQ;
        end else if (!stall_i) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_FAULT;
        end
      end
      S_WAIT: begin
        if (redir_s) begin
          pc_s    = target_s;
          state_s = S_REQ;
        end else begin
          state_s = S_WAIT;
        end
      end
      default: begin
        state_s = S_REQ;
        pc_s    = RESET_PC;
      end
    endcase
  end

  // State, PC, response buffer and latched bus address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_REQ;
      pc_r    <= RESET_PC;
      buf_r   <= 32'h0000_0000;
      addr_r  <= RESET_PC;
      exc_r   <= 4'b0000;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      buf_r   <= buf_s;
      addr_r  <= addr_s;
      exc_r   <= exc_s;
    end
  end

  // Reset forces the bus idle and the result invalid without waiting for a clock.
  assign iport_cyc_o  = rst & cyc_s;
  assign iport_addr_o = addr_out_s;
  assign valid_o      = rst & valid_s;
  assign inst_o       = (rst & valid_s) ? inst_s : NOP_INST;
  assign exc_o        = (rst & valid_s) ? exc_out_s : 4'b0000;
  assign busy_o       = rst & busy_s;
  assign pc_o         = pc_r;
  assign pc4_o        = pc4_s;

`ifdef FETCH_PERF_EN
  logic [31:0] wait_cnt_r;

  // Saturating count of bus cycles spent waiting on memory.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_r <= 32'h0000_0000;
    end else if (iport_cyc_o && !resp_s && (wait_cnt_r != 32'hFFFF_FFFF)) begin
      wait_cnt_r <= wait_cnt_r + 32'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign perf_wait_o = wait_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized memory
// latency, stalls, errors and redirects checked against an instruction-stream model.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        xcpt_i;
  logic [31:0] xcpt_target_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] iport_addr_o;
  logic        iport_cyc_o;
  logic [31:0] iport_data_i;
  logic        iport_ack_i;
  logic        iport_err_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic [3:0]  exc_o;
  logic        valid_o;
  logic        busy_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_wait_o;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .xcpt_i          (xcpt_i),
    .xcpt_target_i   (xcpt_target_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .iport_addr_o    (iport_addr_o),
    .iport_cyc_o     (iport_cyc_o),
    .iport_data_i    (iport_data_i),
    .iport_ack_i     (iport_ack_i),
    .iport_err_i     (iport_err_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .pc4_o           (pc4_o),
    .exc_o           (exc_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_wait_o     (perf_wait_o)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = 32'($urandom_range(0, 63)) << 4;
    if ($urandom_range(0, 7) == 0) t[1] = 1'b1;
    return t;
  endfunction

  // memory model state
  bit          mem_auto, mem_rand, err_en, pend;
  int          mem_wait, wait_left;
  logic [31:0] err_addr, pend_addr;
  bit          last_err;
  logic [31:0] last_addr;

  // instruction-stream model state
  logic [31:0] exp_pc;
  bit          dead;
  int          idle;
  int          perf_model;
  bit          perf_known;

  task automatic mem_respond();
    if (!mem_auto) return;
    iport_ack_i  = 1'b0;
    iport_err_i  = 1'b0;
    iport_data_i = $urandom;
    if (iport_cyc_o) begin
      if (!pend) begin
        pend      = 1'b1;
        pend_addr = iport_addr_o;
        wait_left = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end else begin
        check_val("addr_hold", iport_addr_o, pend_addr);
      end
      if (wait_left == 0) begin
        if ((err_en && iport_addr_o == err_addr) || (mem_rand && $urandom_range(0, 15) == 0))
          iport_err_i = 1'b1;
        else
          iport_ack_i = 1'b1;
        iport_data_i = mem_word(iport_addr_o);
        last_err     = iport_err_i;
        last_addr    = iport_addr_o;
        pend         = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      if (pend && rst) check_val("cyc_drop", 32'(iport_cyc_o), 32'd1);
      pend = 1'b0;
    end
  endtask

  task automatic model_check();
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] exp_exc;
    redir   = xcpt_i | branch_i;
    tgt     = xcpt_i ? xcpt_target_i : branch_target_i;
    exp_exc = 32'd0;
`ifdef FETCH_PERF_EN
    if (perf_known) check_val("perf_wait", perf_wait_o, 32'(perf_model));
    if (!rst) begin
      perf_model = 0;
      perf_known = 1'b1;
    end else if (iport_cyc_o && !iport_ack_i && !iport_err_i) begin
      perf_model++;
    end
`endif
    if (!rst) begin
      check_val("rst_valid", 32'(valid_o), 32'd0);
      check_val("rst_cyc", 32'(iport_cyc_o), 32'd0);
      check_val("rst_inst", inst_o, NOP);
      check_val("rst_exc", 32'(exc_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);
      exp_pc = RESET_PC;
      dead   = 1'b0;
      idle   = 0;
      return;
    end
    check_val("pc4", pc4_o, pc_o + 32'd4);
    if (!iport_cyc_o) check_val("busy_idle", 32'(busy_o), 32'd0);
    else check_val("addr_align", 32'(iport_addr_o[1:0]), 32'd0);
    if (iport_cyc_o && !iport_ack_i && !iport_err_i) check_val("busy_wait", 32'(busy_o), 32'd1);
    if (dead) check_val("valid_after_fault", 32'(valid_o), 32'd0);
    if (!valid_o) begin
      check_val("inv_inst", inst_o, NOP);
      check_val("inv_exc", 32'(exc_o), 32'd0);
    end else begin
      if (exp_pc[1:0] != 2'b00) exp_exc = 32'd1;
      else if (last_err && last_addr == exp_pc) exp_exc = 32'd2;
      else exp_exc = 32'd0;
      check_val("stream_pc", pc_o, exp_pc);
      check_val("stream_exc", 32'(exc_o), exp_exc);
      check_val("stream_inst", inst_o, (exp_exc == 32'd0) ? mem_word(exp_pc) : NOP);
    end
    if (redir) begin
      exp_pc = tgt;
      dead   = 1'b0;
      idle   = 0;
    end else if (valid_o && !stall_i) begin
      if (exp_exc != 32'd0) dead = 1'b1;
      else exp_pc = exp_pc + 32'd4;
      idle = 0;
    end else if (!stall_i && !dead) begin
      idle++;
      if (idle == 40) check_val("progress", 32'(idle), 32'd0);
    end
  endtask

  task automatic drive_cycle();
    #1;
    mem_respond();
    @(negedge clk);
    model_check();
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    drive_cycle();
    next_edge();
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; xcpt_i = 1'b0; branch_i = 1'b0;
    xcpt_target_i = 32'h0; branch_target_i = 32'h0;
    iport_data_i = 32'h0; iport_ack_i = 1'b0; iport_err_i = 1'b0;
    mem_auto = 1'b1; mem_rand = 1'b0; err_en = 1'b0; pend = 1'b0;
    mem_wait = 0; wait_left = 0; err_addr = 32'h0; pend_addr = 32'h0;
    last_err = 1'b0; last_addr = 32'h0; exp_pc = RESET_PC; dead = 1'b0; idle = 0;
    perf_model = 0; perf_known = 1'b0;
    next_edge();

    // zero-wait streaming from reset
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle();
      check_val("t1_valid", 32'(valid_o), 32'd1);
      check_val("t1_pc", pc_o, 32'(4 * i));
      check_val("t1_inst", inst_o, mem_word(32'(4 * i)));
      check_val("t1_exc", 32'(exc_o), 32'd0);
      next_edge();
    end

    // redirect during a 3-wait bus cycle
    rst = 1'b0; tick(); rst = 1'b1; mem_wait = 3;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin branch_i = 1'b1; branch_target_i = 32'h100; end
      drive_cycle();
      check_val("t2_cyc", 32'(iport_cyc_o), 32'd1);
      check_val("t2_addr", iport_addr_o, 32'h0);
      check_val("t2_valid", 32'(valid_o), 32'd0);
      next_edge();
      branch_i = 1'b0;
    end
    drive_cycle();
    check_val("t2_newaddr", iport_addr_o, 32'h100);
    check_val("t2_newcyc", 32'(iport_cyc_o), 32'd1);
    next_edge();
    tick(); tick();
    drive_cycle();
    check_val("t2_valid_new", 32'(valid_o), 32'd1);
    check_val("t2_inst_new", inst_o, mem_word(32'h100));
    next_edge();

    // ack under stall goes to the hold buffer
    rst = 1'b0; tick(); rst = 1'b1; mem_wait = 0; stall_i = 1'b1;
    drive_cycle();
    check_val("t3_valid_ack", 32'(valid_o), 32'd0);
    next_edge();
    for (int c = 0; c < 3; c++) begin
      drive_cycle();
      check_val("t3_cyc", 32'(iport_cyc_o), 32'd0);
      check_val("t3_valid", 32'(valid_o), 32'd1);
      check_val("t3_inst", inst_o, mem_word(32'h0));
      check_val("t3_pc", pc_o, 32'h0);
      next_edge();
    end
    stall_i = 1'b0;
    drive_cycle();
    check_val("t3_rel_inst", inst_o, mem_word(32'h0));
    next_edge();
    drive_cycle();
    check_val("t3_next_pc", pc_o, 32'h4);
    check_val("t3_next_inst", inst_o, mem_word(32'h4));
    next_edge();

    // misaligned branch target, then exception redirect out of WAIT
    rst = 1'b0; tick(); rst = 1'b1;
    branch_i = 1'b1; branch_target_i = 32'h102;
    tick();
    branch_i = 1'b0;
    drive_cycle();
    check_val("t4_nobus", 32'(iport_cyc_o), 32'd0);
    next_edge();
    drive_cycle();
    check_val("t4_valid", 32'(valid_o), 32'd1);
    check_val("t4_exc", 32'(exc_o), 32'd1);
    check_val("t4_inst", inst_o, NOP);
    check_val("t4_pc", pc_o, 32'h102);
    next_edge();
    for (int c = 0; c < 3; c++) begin
      drive_cycle();
      check_val("t4_wait_valid", 32'(valid_o), 32'd0);
      check_val("t4_wait_cyc", 32'(iport_cyc_o), 32'd0);
      next_edge();
    end
    xcpt_i = 1'b1; xcpt_target_i = 32'h200;
    tick();
    xcpt_i = 1'b0;
    drive_cycle();
    check_val("t4_resume_addr", iport_addr_o, 32'h200);
    check_val("t4_resume_inst", inst_o, mem_word(32'h200));
    next_edge();

    // bus error at 0x40, then simultaneous redirects
    rst = 1'b0; tick(); rst = 1'b1; err_en = 1'b1; err_addr = 32'h40;
    repeat (16) tick();
    drive_cycle();
    check_val("t5_err_valid", 32'(valid_o), 32'd0);
    check_val("t5_err_addr", iport_addr_o, 32'h40);
    next_edge();
    drive_cycle();
    check_val("t5_exc", 32'(exc_o), 32'd2);
    check_val("t5_pc", pc_o, 32'h40);
    next_edge();
    err_en = 1'b0;
    xcpt_i = 1'b1; xcpt_target_i = 32'h300; branch_i = 1'b1; branch_target_i = 32'h500;
    tick();
    xcpt_i = 1'b0; branch_i = 1'b0;
    drive_cycle();
    check_val("t5_prio", iport_addr_o, 32'h300);
    next_edge();

    // reset mid-wait with a late ack
    rst = 1'b0; tick(); rst = 1'b1; mem_wait = 3;
    tick();
    rst = 1'b0;
    drive_cycle();
    check_val("t6_cyc_drop", 32'(iport_cyc_o), 32'd0);
    next_edge();
    mem_auto = 1'b0; iport_ack_i = 1'b1; iport_data_i = 32'hDEAD_BEEF;
    drive_cycle();
    check_val("t6_late_valid", 32'(valid_o), 32'd0);
    next_edge();
    iport_ack_i = 1'b0; mem_auto = 1'b1; rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_cycle();
      check_val("t6_addr", iport_addr_o, RESET_PC);
      check_val("t6_valid", 32'(valid_o), 32'd0);
      next_edge();
    end
    drive_cycle();
    check_val("t6_first_inst", inst_o, mem_word(RESET_PC));
    next_edge();
    drive_cycle();
`ifdef FETCH_PERF_EN
    check_val("t6_perf", perf_wait_o, 32'd3);
`endif
    next_edge();

    // randomized traffic
    rst = 1'b0; tick(); rst = 1'b1; mem_rand = 1'b1;
    repeat (3000) begin
      stall_i         = ($urandom_range(0, 3) == 0);
      xcpt_i          = ($urandom_range(0, 39) == 0);
      branch_i        = ($urandom_range(0, 9) == 0);
      xcpt_target_i   = rand_tgt();
      branch_target_i = rand_tgt();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a request/ack handshake with instruction memory.
- Presents inst/pc/pc4/exc plus a valid flag for IF/ID to capture.
- Applies branch and exception redirects. A redirect issued while a bus cycle is outstanding waits for that cycle to complete, then discards its response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, instruction driven whenever valid_o=0 or on a fault.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- stall_i  in  1  hazard unit holds the current fetch result (same signal as stall_ifid)
- xcpt_i  in  1  exception redirect request
- xcpt_target_i  in  32  exception vector
- branch_i  in  1  branch/jump redirect request
- branch_target_i  in  32  branch target
- iport_addr_o  out  32  fetch address
- iport_cyc_o  out  1  bus request
- iport_data_i  in  32  read data, valid with ack
- iport_ack_i  in  1  transfer done
- iport_err_i  in  1  bus error, ends the transfer
- inst_o  out  32  fetched instruction
- pc_o  out  32  PC of inst_o
- pc4_o  out  32  pc_o+4
- exc_o  out  4  bit0 misaligned fetch, bit1 access fault, bits[3:2]=0
- valid_o  out  1  outputs hold a real fetch result this cycle
- busy_o  out  1  waiting on memory; control clears IF/ID when high

Behaviour:
- Reset (rst=0 at posedge):
  - pc<=RESET_PC, state<=REQ, buffer cleared.
  - While rst=0: iport_cyc_o=0, valid_o=0, inst_o=NOP_INST, exc_o=0, busy_o=0.
  - A reset in the middle of a bus cycle drops iport_cyc_o immediately; a late ack is ignored.
- pc_o is always the pc register. pc4_o=pc+4, computed mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Redirect priority: xcpt_i > branch_i. A redirect is accepted in every state regardless of stall_i.
- REQ state:
  - pc[1:0]!=0: iport_cyc_o=0, no bus access; go to FAULT with exc=bit0.
  - Otherwise iport_cyc_o=1, iport_addr_o=pc, busy_o=!(ack|err).
  - ack & !redirect & !stall_i: valid_o=1 and inst_o=iport_data_i in the same cycle; pc<=pc+4; stay in REQ (back-to-back, 1 instr/cycle with a zero-wait memory).
  - ack & stall_i: latch data into buffer; go to HOLD.
  - err: go to FAULT with exc=bit1.
  - Redirect with ack or err in the same cycle: response discarded, pc<=target, stay in REQ.
  - Redirect without ack: pc<=target, go to DISCARD.
- HOLD state:
  - iport_cyc_o=0, valid_o=1, inst_o=buffer.
  - !stall_i: pc<=pc+4, go to REQ.
  - Redirect: buffer dropped, pc<=target, go to REQ.
- DISCARD state:
  - iport_cyc_o=1 with the old address held stable (latched), valid_o=0, busy_o=1.
  - On ack or err: go to REQ; data and error are ignored.
  - A new redirect in DISCARD only updates pc.
- FAULT state:
  - valid_o=1, inst_o=NOP_INST, exc_o=latched code, iport_cyc_o=0.
  - When !stall_i (result consumed): go to WAIT.
- WAIT state:
  - valid_o=0, exc_o=0, iport_cyc_o=0; PC is frozen.
  - Only a redirect leaves WAIT (pc<=target, go to REQ).
- Handshake rule: iport_addr_o and iport_cyc_o stay constant from cyc assertion until ack/err. Ack with cyc low is ignored.
- Whenever valid_o=0: inst_o=NOP_INST and exc_o=0.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds output perf_wait_o[31:0], which counts cycles with iport_cyc_o=1 & !iport_ack_i & !iport_err_i.
  - The counter saturates at 0xFFFF_FFFF and clears on reset.
- FETCH_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Release reset, zero-wait memory returning addr^0xA5A5A5A5 -> valid_o every cycle from the first cycle; pc_o sequence 0,4,8,C; pc4_o=pc_o+4; exc_o=0.
- 3-wait-state memory, redirect branch_i=1/target=0x100 on wait cycle 1 -> cyc held with addr 0x0 until ack, valid_o=0 throughout, next request addr=0x100 and the old data never appears.
- Ack while stall_i=1 for 4 cycles -> cyc low during stall, inst_o stable from buffer, valid_o=1; after release pc_o advances by exactly 4 and no instruction is lost or duplicated.
- Branch to 0x102 -> no bus cycle; one valid_o with exc_o=4'b0001 and inst_o=0x00000013; then valid_o=0 until xcpt_i with target 0x200, after which fetch resumes at 0x200.
- iport_err_i at 0x40 -> exc_o=4'b0010, pc_o=0x40; xcpt_i and branch_i asserted together -> xcpt target wins.
- rst=0 pulse mid-wait, then late ack -> ack ignored; first request after release at RESET_PC. With FETCH_PERF_EN, perf_wait_o equals the injected wait count.
